// File: rtl/msx_slot_expander_if.sv
// CPU-side bus of the slot expander: T80 memory strobes in, FFFFh readback,
// write-block and memory-request pulse out.
interface msx_slot_expander_if;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_dout;
  logic        cpu_mreq;
  logic        cpu_rd;
  logic        cpu_wr;
  logic        cpu_m1;
  logic [7:0]  sub_d;
  logic        sub_oe;
  logic        slot_wr_block;
  logic        mem_req;

  modport master (
    output cpu_addr, cpu_dout, cpu_mreq, cpu_rd, cpu_wr, cpu_m1,
    input  sub_d, sub_oe, slot_wr_block, mem_req
  );

  modport slave (
    input  cpu_addr, cpu_dout, cpu_mreq, cpu_rd, cpu_wr, cpu_m1,
    output sub_d, sub_oe, slot_wr_block, mem_req
  );
endinterface

// File: rtl/msx_slot_expander.sv
// MSX primary/secondary slot decoder with per-slot FFFFh subslot registers.
// Optional macro SUBSLOT_READBACK_EN enables the inverted FFFFh readback path.
module msx_slot_expander #(
  parameter logic [3:0] EXP_DEFAULT = 4'b0000
) (
  input  logic                      clk21m,
  input  logic                      reset_n,
  msx_slot_expander_if.slave        bus,
  input  logic                      ppi_cs,
  input  logic [7:0]                ppi_port_a,
  input  logic                      cfg_load,
  input  logic [3:0]                cfg_expanded,
  output logic [1:0]                active_slot,
  output logic [1:0]                active_subslot,
  output logic                      map_valid
);

  logic            r_map_valid;
  logic            r_ack;
  logic [3:0]      r_exp;
  logic [3:0][7:0] w_sub_all;
  logic [1:0]      w_page;
  logic [1:0]      w_pri;
  logic [1:0]      w_pri_p3;
  logic [7:0]      w_sub_sel;
  logic [7:0]      w_sub_p3;
  logic            w_ffff_hit;
  logic            w_wr_hit;
  logic            w_load;

  assign w_page     = bus.cpu_addr[15:14];
  assign w_pri      = r_map_valid ? ppi_port_a[{w_page, 1'b0} +: 2] : 2'd0;
  assign w_pri_p3   = r_map_valid ? ppi_port_a[7:6] : 2'd0;
  assign w_sub_sel  = w_sub_all[w_pri];
  assign w_sub_p3   = w_sub_all[w_pri_p3];

  assign active_slot    = w_pri;
  assign active_subslot = r_exp[w_pri] ? w_sub_sel[{w_page, 1'b0} +: 2] : 2'd0;
  assign map_valid      = r_map_valid;

  // The register is addressed in whatever slot page 3 currently maps to.
  assign w_ffff_hit = (bus.cpu_addr == 16'hFFFF) & bus.cpu_mreq &
                      r_exp[w_pri_p3] & ~bus.cpu_m1;
  assign w_wr_hit   = w_ffff_hit & bus.cpu_wr;
  assign w_load     = w_wr_hit & ~r_ack;

  // Strobe-driven outputs are gated by reset so they drop the moment reset asserts.
  assign bus.slot_wr_block = reset_n & w_wr_hit;
  assign bus.mem_req       = reset_n & bus.cpu_mreq & (bus.cpu_rd | bus.cpu_wr) & ~r_ack;

`ifdef SUBSLOT_READBACK_EN
  logic w_rd_hit;
  assign w_rd_hit   = reset_n & w_ffff_hit & bus.cpu_rd;
  assign bus.sub_oe = w_rd_hit;
  assign bus.sub_d  = w_rd_hit ? ~w_sub_p3 : 8'hFF;
`else
  logic [7:0] w_unused_sub;
  assign w_unused_sub = w_sub_p3;
  assign bus.sub_oe   = 1'b0;
  assign bus.sub_d    = 8'hFF;
`endif

  always_ff @(posedge clk21m or negedge reset_n) begin
    if (!reset_n) begin
      r_map_valid <= 1'b0;
      r_ack       <= 1'b0;
      r_exp       <= EXP_DEFAULT;
    end else begin
      if (ppi_cs)
        r_map_valid <= 1'b1;
      if (!bus.cpu_mreq)
        r_ack <= 1'b0;
      else if (bus.cpu_rd | bus.cpu_wr)
        r_ack <= 1'b1;
      if (cfg_load)
        r_exp <= cfg_expanded;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_sub
      logic [7:0] r_sub;
      // A slot being removed from the mask is cleared even if written this edge.
      always_ff @(posedge clk21m or negedge reset_n) begin
        if (!reset_n)
          r_sub <= 8'h00;
        else if (cfg_load && !cfg_expanded[gi])
          r_sub <= 8'h00;
        else if (w_load && (w_pri_p3 == 2'(gi)))
          r_sub <= bus.cpu_dout;
      end
      assign w_sub_all[gi] = r_sub;
    end
  endgenerate

endmodule

// File: tb/tb_msx_slot_expander.sv
// Self-checking bench for msx_slot_expander: decode vector table, scoreboard
// of expected values, and hand-written multi-cycle bus sequences.
module tb_msx_slot_expander;

  logic       clk21m = 1'b0;
  logic       reset_n = 1'b0;
  logic       ppi_cs;
  logic [7:0] ppi_port_a;
  logic       cfg_load;
  logic [3:0] cfg_expanded;
  logic [1:0] active_slot;
  logic [1:0] active_subslot;
  logic       map_valid;

  msx_slot_expander_if bus();

  msx_slot_expander #(.EXP_DEFAULT(4'b0000)) dut (
    .clk21m         (clk21m),
    .reset_n        (reset_n),
    .bus            (bus),
    .ppi_cs         (ppi_cs),
    .ppi_port_a     (ppi_port_a),
    .cfg_load       (cfg_load),
    .cfg_expanded   (cfg_expanded),
    .active_slot    (active_slot),
    .active_subslot (active_subslot),
    .map_valid      (map_valid)
  );

  always #5 clk21m = ~clk21m;

  int checks = 0;
  int errors = 0;
  int pulse_cnt = 0;

  always @(negedge clk21m)
    if (bus.mem_req === 1'b1) pulse_cnt++;

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  ppi;
    logic [1:0]  exp_slot;
    logic [1:0]  exp_sub;
  } vec_t;
  vec_t vt [10];

  typedef struct {
    string       name;
    logic [31:0] val;
  } exp_t;
  exp_t sb_q [$];

`ifdef SUBSLOT_READBACK_EN
  localparam logic       RB_OE = 1'b1;
  localparam logic [7:0] RB_D  = 8'hE4;
`else
  localparam logic       RB_OE = 1'b0;
  localparam logic [7:0] RB_D  = 8'hFF;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else
      $display("ok   %s: %h", name, act);
  endtask

  task automatic sb_push(input string name, input logic [31:0] val);
    exp_t e;
    e.name = name;
    e.val  = val;
    sb_q.push_back(e);
  endtask

  task automatic sb_check(input logic [31:0] act);
    exp_t e;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL sb_empty: got %h expected queued value", act);
    end else begin
      e = sb_q.pop_front();
      chk(e.name, act, e.val);
    end
  endtask

  task automatic step();
    @(posedge clk21m);
    #2;
  endtask

  task automatic run_vec(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      bus.cpu_addr = vt[i].addr;
      ppi_port_a   = vt[i].ppi;
      sb_push($sformatf("vec%0d_slot", i), 32'(vt[i].exp_slot));
      sb_push($sformatf("vec%0d_sub", i), 32'(vt[i].exp_sub));
      #1;
      sb_check(32'(active_slot));
      sb_check(32'(active_subslot));
    end
  endtask

  task automatic bus_idle();
    bus.cpu_mreq = 1'b0;
    bus.cpu_rd   = 1'b0;
    bus.cpu_wr   = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    vt[0] = '{16'h4000, 8'hE4, 2'd1, 2'd0};
    vt[1] = '{16'hC000, 8'hE4, 2'd3, 2'd0};
    vt[2] = '{16'h0000, 8'hE4, 2'd0, 2'd0};
    vt[3] = '{16'h8000, 8'hE4, 2'd2, 2'd0};
    vt[4] = '{16'h0000, 8'hFF, 2'd3, 2'd3};
    vt[5] = '{16'h4000, 8'hFF, 2'd3, 2'd2};
    vt[6] = '{16'h8000, 8'hFF, 2'd3, 2'd1};
    vt[7] = '{16'hC000, 8'hFF, 2'd3, 2'd0};
    vt[8] = '{16'hC000, 8'hC0, 2'd3, 2'd0};
    vt[9] = '{16'h0000, 8'hC0, 2'd0, 2'd0};

    bus.cpu_addr = 16'h0000;
    bus.cpu_dout = 8'h00;
    bus.cpu_m1   = 1'b0;
    bus.cpu_mreq = 1'b1;
    bus.cpu_rd   = 1'b1;
    bus.cpu_wr   = 1'b0;
    ppi_cs       = 1'b0;
    ppi_port_a   = 8'h00;
    cfg_load     = 1'b0;
    cfg_expanded = 4'b0000;

    // Reset state, with a read strobe active to exercise mem_req gating
    repeat (2) step();
    #1;
    chk("rst_slot", 32'(active_slot), 0);
    chk("rst_sub", 32'(active_subslot), 0);
    chk("rst_sub_oe", 32'(bus.sub_oe), 0);
    chk("rst_sub_d", 32'(bus.sub_d), 32'hFF);
    chk("rst_wr_block", 32'(bus.slot_wr_block), 0);
    chk("rst_mem_req", 32'(bus.mem_req), 0);
    chk("rst_map_valid", 32'(map_valid), 0);
    bus_idle();
    step();
    reset_n = 1'b1;

    // No PPI access yet: slot 0
    bus.cpu_addr = 16'h4000;
    ppi_port_a   = 8'hE4;
    #1;
    chk("noppi_slot", 32'(active_slot), 0);
    chk("noppi_map_valid", 32'(map_valid), 0);
    step();
    ppi_cs = 1'b1;
    step();
    ppi_cs = 1'b0;
    #1;
    chk("ppi_map_valid", 32'(map_valid), 1);
    run_vec(0, 3);

    // Expand slot 3 and write 1Bh to FFFFh with the strobe held 6 clocks
    cfg_expanded = 4'b1000;
    cfg_load     = 1'b1;
    ppi_port_a   = 8'hC0;
    step();
    cfg_load     = 1'b0;
    bus.cpu_addr = 16'hFFFF;
    bus.cpu_dout = 8'h1B;
    bus.cpu_mreq = 1'b1;
    bus.cpu_wr   = 1'b1;
    p0 = pulse_cnt;
    for (int c = 0; c < 6; c++) begin
      #1;
      chk($sformatf("wr_block_c%0d", c), 32'(bus.slot_wr_block), 1);
      step();
      if (c == 0) bus.cpu_dout = 8'h77;
    end
    bus_idle();
    #1;
    chk("wr_mem_req_pulses", 32'(pulse_cnt - p0), 1);
    step();
    run_vec(4, 9);

    // Read FFFFh in the expanded slot
    ppi_port_a   = 8'hC0;
    bus.cpu_addr = 16'hFFFF;
    bus.cpu_mreq = 1'b1;
    bus.cpu_rd   = 1'b1;
    #1;
    chk("rd_sub_oe", 32'(bus.sub_oe), 32'(RB_OE));
    chk("rd_sub_d", 32'(bus.sub_d), 32'(RB_D));
    chk("rd_wr_block", 32'(bus.slot_wr_block), 0);
    step();
    bus_idle();
    step();

    // FFFFh write while page 3 maps to non-expanded slot 1
    ppi_port_a   = 8'h40;
    bus.cpu_dout = 8'h55;
    bus.cpu_mreq = 1'b1;
    bus.cpu_wr   = 1'b1;
    p0 = pulse_cnt;
    #1;
    chk("nx_wr_block", 32'(bus.slot_wr_block), 0);
    chk("nx_sub_oe", 32'(bus.sub_oe), 0);
    repeat (2) step();
    bus_idle();
    #1;
    chk("nx_mem_req_pulses", 32'(pulse_cnt - p0), 1);
    step();
    ppi_port_a   = 8'hFF;
    bus.cpu_addr = 16'h0000;
    #1;
    chk("nx_sub3_kept", 32'(active_subslot), 3);

    // Memory reads with wait states: one pulse per bus cycle
    bus.cpu_addr = 16'h1234;
    for (int n = 0; n < 2; n++) begin
      bus.cpu_mreq = 1'b1;
      bus.cpu_rd   = 1'b1;
      p0 = pulse_cnt;
      sb_push($sformatf("rd_cycle%0d_pulses", n), 1);
      repeat (n == 0 ? 10 : 3) step();
      bus_idle();
      #1;
      sb_check(32'(pulse_cnt - p0));
      step();
    end

    // cfg_load removing slot 3 on the same edge as an FFFFh write
    ppi_port_a   = 8'hFF;
    bus.cpu_addr = 16'hFFFF;
    bus.cpu_dout = 8'hAA;
    bus.cpu_mreq = 1'b1;
    bus.cpu_wr   = 1'b1;
    cfg_expanded = 4'b0000;
    cfg_load     = 1'b1;
    step();
    cfg_load = 1'b0;
    bus_idle();
    bus.cpu_addr = 16'h0000;
    #1;
    chk("clr_sub_p0", 32'(active_subslot), 0);
    step();
    cfg_expanded = 4'b1000;
    cfg_load     = 1'b1;
    step();
    cfg_load = 1'b0;
    #1;
    chk("clr_reexp_p0", 32'(active_subslot), 0);
    bus.cpu_addr = 16'h4000;
    #1;
    chk("clr_reexp_p1", 32'(active_subslot), 0);

    // Reset asserted in the middle of an FFFFh write
    bus.cpu_addr = 16'hFFFF;
    bus.cpu_dout = 8'h3C;
    bus.cpu_mreq = 1'b1;
    bus.cpu_wr   = 1'b1;
    #1;
    chk("mid_wr_block_pre", 32'(bus.slot_wr_block), 1);
    step();
    #1;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_slot", 32'(active_slot), 0);
    chk("mid_rst_sub", 32'(active_subslot), 0);
    chk("mid_rst_wr_block", 32'(bus.slot_wr_block), 0);
    chk("mid_rst_mem_req", 32'(bus.mem_req), 0);
    chk("mid_rst_sub_d", 32'(bus.sub_d), 32'hFF);
    chk("mid_rst_map_valid", 32'(map_valid), 0);
    step();
    reset_n = 1'b1;
    #1;
    chk("rel_mem_req_hi", 32'(bus.mem_req), 1);
    chk("rel_wr_block", 32'(bus.slot_wr_block), 0);
    step();
    #1;
    chk("rel_mem_req_lo", 32'(bus.mem_req), 0);
    bus_idle();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/msx_slot_expander.md
Name: msx_slot_expander

Overview:
- Primary/secondary slot decoder between the T80 bus and the slot/cartridge block.
- Derives the active primary slot from PPI port A.
- Holds one secondary-slot register per expanded primary slot, accessed at address FFFFh.
- Produces the active (slot, subslot) pair and a one-shot memory request that drive downstream slot decoding and SDRAM/BRAM access.

Parameters:
- EXP_DEFAULT, 4'b0000, reset-time mask of expanded primary slots; bit n set means slot n is expanded. Used only until `cfg_load`.

Ports:
- clk21m  in  1  system clock, 21.48 MHz.
- reset_n  in  1  asynchronous active-low reset.
- cpu_addr  in  16  CPU address bus.
- cpu_dout  in  8  data from CPU.
- cpu_mreq  in  1  memory request, active high.
- cpu_rd  in  1  read strobe, active high.
- cpu_wr  in  1  write strobe, active high.
- cpu_m1  in  1  M1 cycle, active high.
- ppi_cs  in  1  PPI chip select, active high.
- ppi_port_a  in  8  PPI port A output (primary slot map).
- cfg_load  in  1  one-clock strobe; latch `cfg_expanded`.
- cfg_expanded  in  4  runtime expanded-slot mask.
- active_slot  out  2  primary slot of the current address.
- active_subslot  out  2  secondary slot of the current address.
- sub_d  out  8  readback data for FFFFh.
- sub_oe  out  1  high when `sub_d` must override slot data to the CPU.
- slot_wr_block  out  1  suppresses the write toward the slots while the FFFFh register is being written.
- mem_req  out  1  one-clock pulse per memory bus cycle.
- map_valid  out  1  PPI has been accessed since reset.

Behaviour:
- Reset (`reset_n` low, async), in effect immediately:
  - `map_valid`=0, expanded mask=EXP_DEFAULT, all four `sub_reg`=8'h00, access-ack flag=0.
  - Outputs: `active_slot`=0, `active_subslot`=0, `sub_oe`=0, `sub_d`=8'hFF, `slot_wr_block`=0, `mem_req`=0.
- map_valid: set on any clk21m edge with `ppi_cs`=1; sticky until reset.
- Page: `cpu_addr`[15:14].
- Primary slot (combinational):
  - `map_valid`=0 -> 0.
  - Otherwise `ppi_port_a`[2*page+1:2*page].
- Secondary slot (combinational):
  - Primary slot expanded -> `sub_reg`[slot][2*page+1:2*page].
  - Otherwise 0.
- FFFFh hit: `cpu_addr`=FFFFh & `cpu_mreq` & primary slot of page 3 expanded & `cpu_m1`=0.
- Read hit (`cpu_rd`=1): `sub_oe`=1 and `sub_d`=~`sub_reg`[slot], combinational, zero latency. Otherwise `sub_oe`=0.
- Write hit (`cpu_wr`=1):
  - `slot_wr_block`=1 for the whole strobe.
  - `sub_reg`[slot] loads `cpu_dout` on the first clk21m edge of the strobe only (ack-gated). Repeated edges within the same strobe do not reload.
- FFFFh access to a non-expanded slot: no register change, `sub_oe`=0, `slot_wr_block`=0; the access passes through to the slots.
- mem_req: `cpu_mreq` & (`cpu_rd` | `cpu_wr`) & ~ack.
  - ack sets on the next clk21m edge and clears when `cpu_mreq`=0.
  - Result: exactly one clk21m-wide pulse per bus cycle, regardless of wait states.
- cfg_load: latches `cfg_expanded` on that edge. If a slot becomes non-expanded, its `sub_reg` is cleared to 0 on the same edge.
- Simultaneous `cfg_load` and FFFFh write: the write uses the mask in effect before the edge. The clear applies after (clear wins for a slot being removed).
- Reset asserted mid-cycle: all state cleared immediately. After release, a still-active strobe produces `mem_req` on the next edge (ack=0).

Optional Feature:
- Macro SUBSLOT_READBACK_EN.
- Defined: FFFFh reads in expanded slots return ~`sub_reg` via `sub_oe`/`sub_d` as above.
- Undefined:
  - `sub_oe` is tied 0 and `sub_d` is tied 8'hFF; reads pass through to the slots.
  - Register writes, `slot_wr_block` and subslot decoding are unchanged.

Test Plan:
- Reset, then read 4000h with no PPI access -> `active_slot`=0, `active_subslot`=0, `map_valid`=0. Pulse `ppi_cs` with `ppi_port_a`=8'hE4 -> `map_valid`=1; addr 4000h -> slot 1; addr C000h -> slot 3.
- `cfg_expanded`=4'b1000 + `cfg_load`, `ppi_port_a`=8'hC0. Write 8'h1B to FFFFh with wr held 6 clocks -> `sub_reg`[3]=8'h1B loaded once, `slot_wr_block`=1 throughout. Addr 0000h -> subslot 3; addr 4000h -> subslot 2; addr 8000h -> subslot 1; addr C000h -> subslot 0.
- Read FFFFh in the same setup -> `sub_oe`=1, `sub_d`=8'hE4 (8'hFF and `sub_oe`=0 when built without SUBSLOT_READBACK_EN).
- Port A selects non-expanded slot 1 for page 3; write 8'h55 to FFFFh -> `sub_reg` unchanged, `slot_wr_block`=0, `mem_req` pulses.
- Memory read held 10 clocks with wait -> `mem_req` high exactly 1 clock. A second cycle after `cpu_mreq` falls -> another single pulse.
- `sub_reg`[3]=8'h1B, assert `cfg_load` with `cfg_expanded`=0 in the same clock as an FFFFh write -> `sub_reg`[3]=0, subslot 0 everywhere. Assert `reset_n`=0 mid-write -> all outputs at reset values within the same clock.
